galaga_bullet_scheduler: RTL and testbench

Per-frame sequencer for the player-bullet slot pool in the GALAGA playfield.
- On each frame tick it walks all bullet slots, one per cycle.
- It advances live bullets upward and retires bullets that leave the top edge.
- It spawns at most one new bullet per frame into the first free slot, subject to a fire cooldown.
- It drives the write port of the player-bullet position register file, the same storage the renderer reads for pixel state.

---
 rtl/galaga_pkg.sv | 38 +++
 rtl/galaga_bullet_scheduler_if.sv | 29 ++
 rtl/galaga_bullet_scheduler.sv | 155 +++++++++++++++
 tb/tb_galaga_bullet_scheduler.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/galaga_pkg.sv
// Shared GALAGA playfield definitions: position encoding, sprite sizes,
// the dead-slot marker and the bullet scheduler state type.
package galaga_pkg;

    localparam int POS_W = 19;
    localparam int X_W   = 10;
    localparam int Y_W   = 9;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    localparam int PLAYER_WIDTH  = 24;
    localparam int PLAYER_HEIGHT = 16;
    localparam int BULLET_WIDTH  = 4;
    localparam int BULLET_HEIGHT = 16;

    // A slot whose x equals DEAD_X is free; the full dead position is parked off-screen.
    localparam logic [X_W-1:0]   DEAD_X        = 10'd720;
    localparam logic [Y_W-1:0]   DEAD_Y        = 9'd500;
    localparam logic [POS_W-1:0] DEAD_POSITION = {DEAD_X, DEAD_Y};

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
    } pos_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DONE
    } sched_state_e;

    // Only x is inspected: any slot parked at DEAD_X counts as free.
    function automatic logic is_dead(input pos_t pos);
        return pos.x == DEAD_X;
    endfunction

endpackage

// File: rtl/galaga_bullet_scheduler_if.sv
// Read/write port of the player-bullet position register file. The
// scheduler is the master; the register file is the slave and answers
// rd_data combinationally for rd_idx.
interface galaga_bullet_scheduler_if;
    import galaga_pkg::*;

    logic [3:0] rd_idx;
    pos_t       rd_data;
    logic       wr_en;
    logic [3:0] wr_idx;
    pos_t       wr_data;

    modport master (
        output rd_idx,
        output wr_en,
        output wr_idx,
        output wr_data,
        input  rd_data
    );

    modport slave (
        input  rd_idx,
        input  wr_en,
        input  wr_idx,
        input  wr_data,
        output rd_data
    );

endinterface

// File: rtl/galaga_bullet_scheduler.sv
// Per-frame walker over the player-bullet slot pool: advances live bullets,
// retires those leaving the top edge and spawns at most one bullet per frame
// into the first slot found free, gated by a fire cooldown.
module galaga_bullet_scheduler
    import galaga_pkg::*;
#(
    parameter int MAX_PLAYER_BULLET = 16,
    parameter int BULLET_SPEED      = 8,
    parameter int FIRE_COOLDOWN     = 12
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst,
    input  logic                       i_FrameTick,
    input  logic                       i_Fire,
    input  pos_t                       i_PlayerPos,
    galaga_bullet_scheduler_if.master  pos_file,
    output logic                       o_Busy,
    output logic [4:0]                 o_ActiveCnt,
    output logic                       o_FireAck
);

    localparam logic [3:0]     IDX_LAST      = 4'(MAX_PLAYER_BULLET - 1);
    localparam logic [Y_W-1:0] SPEED_Y       = Y_W'(BULLET_SPEED);
    localparam logic [Y_W-1:0] SPAWN_DY      = Y_W'(BULLET_HEIGHT);
    localparam logic [X_W-1:0] SPAWN_DX      = X_W'((PLAYER_WIDTH - BULLET_WIDTH) / 2);
    localparam logic [7:0]     COOLDOWN_INIT = 8'(FIRE_COOLDOWN);

    sched_state_e state_q, state_d;
    logic [3:0]   idx_q, idx_d;
    logic [7:0]   cooldown_q, cooldown_d;
    logic [4:0]   live_acc_q, live_acc_d;
    logic [4:0]   active_cnt_q, active_cnt_d;
    logic         spawn_pending_q, spawn_pending_d;
    logic         spawned_q, spawned_d;
    pos_t         player_pos_q, player_pos_d;

    pos_t         spawn_pos;
    pos_t         rd_pos;
    logic         wr_en;
    pos_t         wr_data;
    logic         fire_ack;

    // Spawn position centres the bullet on the player and sits it just above, clamped at the top.
    always_comb begin
        spawn_pos.x = player_pos_q.x + SPAWN_DX;
        spawn_pos.y = (player_pos_q.y < SPAWN_DY) ? '0 : player_pos_q.y - SPAWN_DY;
    end

    // Next-state and write-port logic for the IDLE -> SCAN -> DONE pass.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
        state_d         = state_q;
        idx_d           = idx_q;
        cooldown_d      = cooldown_q;
        live_acc_d      = live_acc_q;
        active_cnt_d    = active_cnt_q;
        spawn_pending_d = spawn_pending_q;
        spawned_d       = spawned_q;
        player_pos_d    = player_pos_q;
        wr_en           = 1'b0;
        wr_data         = '0;
        fire_ack        = 1'b0;
        rd_pos          = pos_file.rd_data;

        unique case (state_q)
            ST_IDLE: begin
                if (i_FrameTick) begin
                    spawn_pending_d = i_Fire && (cooldown_q == 8'd0);
                    player_pos_d    = i_PlayerPos;
                    idx_d           = 4'd0;
                    live_acc_d      = 5'd0;
                    spawned_d       = 1'b0;
                    state_d         = ST_SCAN;
                end
            end

            ST_SCAN: begin
                if (is_dead(rd_pos)) begin
                    // Only slots already free when read are eligible; one spawn per pass.
                    if (spawn_pending_q && !spawned_q) begin
                        wr_en      = 1'b1;
                        wr_data    = spawn_pos;
                        spawned_d  = 1'b1;
                        live_acc_d = live_acc_q + 5'd1;
                    end
                end else if (rd_pos.y < SPEED_Y) begin
                    // Retire before subtracting so y never wraps.
                    wr_en   = 1'b1;
                    wr_data = DEAD_POSITION;
                end else begin
                    wr_en      = 1'b1;
                    wr_data.x  = rd_pos.x;
                    wr_data.y  = rd_pos.y - SPEED_Y;
                    live_acc_d = live_acc_q + 5'd1;
                end

                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end

            ST_DONE: begin
                active_cnt_d = live_acc_q;
                fire_ack     = spawned_q;
                if (spawned_q) begin
                    cooldown_d = COOLDOWN_INIT;
                end else if (cooldown_q != 8'd0) begin
                    cooldown_d = cooldown_q - 8'd1;
                end
                spawned_d = 1'b0;
                state_d   = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and counter registers; reset clears any partially completed pass.
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q         <= ST_IDLE;
            idx_q           <= 4'd0;
            cooldown_q      <= 8'd0;
            live_acc_q      <= 5'd0;
            active_cnt_q    <= 5'd0;
            spawn_pending_q <= 1'b0;
            spawned_q       <= 1'b0;
            player_pos_q    <= '0;
        end else begin
            // NOTE: non-blocking updates so every flop samples the pre-edge values of the others.
            state_q         <= state_d;
            idx_q           <= idx_d;
            cooldown_q      <= cooldown_d;
            live_acc_q      <= live_acc_d;
            active_cnt_q    <= active_cnt_d;
            spawn_pending_q <= spawn_pending_d;
            spawned_q       <= spawned_d;
            player_pos_q    <= player_pos_d;
        end
    end

    assign pos_file.rd_idx  = idx_q;
    assign pos_file.wr_idx  = idx_q;
    assign pos_file.wr_en   = wr_en;
    assign pos_file.wr_data = wr_data;

    assign o_Busy      = (state_q != ST_IDLE);
    assign o_ActiveCnt = active_cnt_q;
    assign o_FireAck   = fire_ack;

endmodule

// File: tb/tb_galaga_bullet_scheduler.sv
// Directed bench for galaga_bullet_scheduler. The bench owns the position
// register file, answers reads combinationally and applies writes just
// after each rising edge; outputs are sampled on the falling edge.
module tb_galaga_bullet_scheduler;

    logic        clk;
    logic        rst_n;
    logic        frame_tick;
    logic        fire;
    logic [18:0] player_pos;
    logic        busy;
    logic [4:0]  active_cnt;
    logic        fire_ack;

    logic [18:0] pos_file [16];

    int checks;
    int errors;
    int wr_total;
    int ack_total;
    int busy_total;
    int idx_mismatch;
    int pass_cyc;
    int ack_cyc;
    int         wlog_idx  [$];
    logic [18:0] wlog_data [$];
    int         wlog_cyc  [$];

    localparam logic [18:0] DEAD = {10'd720, 9'd500};

    galaga_bullet_scheduler_if pf ();

    assign pf.rd_data = pos_file[pf.rd_idx];

    galaga_bullet_scheduler dut (
        .i_Clk       (clk),
        .i_Rst       (rst_n),
        .i_FrameTick (frame_tick),
        .i_Fire      (fire),
        .i_PlayerPos (player_pos),
        .pos_file    (pf),
        .o_Busy      (busy),
        .o_ActiveCnt (active_cnt),
        .o_FireAck   (fire_ack)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [18:0] mk(input int x, input int y);
        return {10'(x), 9'(y)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_file();
        for (int i = 0; i < 16; i++) pos_file[i] = DEAD;
    endtask

    // Sample at the falling edge, then commit any write just after the rising edge.
    task automatic step();
        logic        we;
        logic [3:0]  wi;
        logic [18:0] wd;
        we = rst_n && pf.wr_en;
        wi = pf.wr_idx;
        wd = pf.wr_data;
        if (rst_n) begin
            if (pf.wr_en) begin
                wr_total++;
                wlog_idx.push_back(int'(pf.wr_idx));
                wlog_data.push_back(pf.wr_data);
                wlog_cyc.push_back(pass_cyc);
                if (pf.wr_idx != pf.rd_idx) idx_mismatch++;
            end
            if (fire_ack) begin
                ack_total++;
                ack_cyc = pass_cyc;
            end
            if (busy) busy_total++;
        end
        pass_cyc++;
        @(posedge clk);
        #1;
        if (we) pos_file[wi] = wd;
        @(negedge clk);
    endtask

    task automatic start_pass(input logic fire_in);
        wlog_idx.delete();
        wlog_data.delete();
        wlog_cyc.delete();
        ack_cyc    = -1;
        fire       = fire_in;
        frame_tick = 1'b1;
        pass_cyc   = -1;
        step();
        frame_tick = 1'b0;
        fire       = 1'b0;
    endtask

    // One full frame pass; retick_at >= 0 pulses a stray tick at that slot cycle.
    task automatic run_pass(input logic fire_in, input int retick_at);
        start_pass(fire_in);
        for (int n = 0; n < 40 && busy; n++) begin
            if (n == retick_at) frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
        end
        check("pass_terminates", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int a0;
        int b0;
        clk          = 1'b0;
        rst_n        = 1'b0;
        frame_tick   = 1'b0;
        fire         = 1'b0;
        player_pos   = mk(302, 372);
        checks       = 0;
        errors       = 0;
        wr_total     = 0;
        ack_total    = 0;
        busy_total   = 0;
        idx_mismatch = 0;
        pass_cyc     = 0;
        ack_cyc      = -1;
        clear_file();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_wr_en",      32'(pf.wr_en),   32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_fire_ack",   32'(fire_ack),   32'd0);
        check("rst_active_cnt", 32'(active_cnt), 32'd0);
        check("rst_rd_idx",     32'(pf.rd_idx),  32'd0);
        check("rst_wr_idx",     32'(pf.wr_idx),  32'd0);
        check("rst_wr_data",    32'(pf.wr_data), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Empty pool, fire: spawn into slot 0 at T+1, ack at T+17
        b0 = busy_total;
        run_pass(1'b1, -1);
        check("spawn_write_count", 32'(wlog_idx.size()), 32'd1);
        if (wlog_idx.size() >= 1) begin
            check("spawn_idx",  32'(wlog_idx[0]),  32'd0);
            check("spawn_data", 32'(wlog_data[0]), 32'(mk(312, 356)));
            check("spawn_cyc",  32'(wlog_cyc[0]),  32'd0);
        end
        check("spawn_ack_cyc",    32'(ack_cyc),            32'd16);
        check("spawn_busy_cyc",   32'(busy_total - b0),    32'd17);
        check("spawn_active_cnt", 32'(active_cnt),         32'd1);
        check("spawn_file",       32'(pos_file[0]),        32'(mk(312, 356)));

        // Advance slot 0, retire slot 3 (y below speed)
        pos_file[3] = mk(100, 5);
        run_pass(1'b0, -1);
        check("adv_write_count", 32'(wlog_idx.size()), 32'd2);
        if (wlog_idx.size() >= 2) begin
            check("adv_idx0",  32'(wlog_idx[0]),  32'd0);
            check("adv_data0", 32'(wlog_data[0]), 32'(mk(312, 348)));
            check("adv_idx1",  32'(wlog_idx[1]),  32'd3);
            check("adv_data1", 32'(wlog_data[1]), 32'(DEAD));
        end
        check("adv_no_ack",     32'(ack_cyc),    32'hFFFF_FFFF);
        check("adv_active_cnt", 32'(active_cnt), 32'd1);

        // Fire held for 30 frames from an empty pool: acks at frames 0, 13, 26
        do_reset();
        clear_file();
        for (int f = 0; f < 30; f++) begin
            a0 = ack_total;
            run_pass(1'b1, -1);
            check($sformatf("hold_ack_f%0d", f), 32'(ack_total - a0), (f % 13 == 0) ? 32'd1 : 32'd0);
        end
        check("hold_active_cnt", 32'(active_cnt), 32'd3);

        // Full pool: every slot advances, spawn dropped, cooldown untouched
        do_reset();
        for (int i = 0; i < 16; i++) pos_file[i] = mk(40 + i * 30, 100 + i * 10);
        run_pass(1'b1, -1);
        check("full_write_count", 32'(wlog_idx.size()), 32'd16);
        for (int i = 0; i < 16 && i < wlog_idx.size(); i++) begin
            check($sformatf("full_data%0d", i), 32'(wlog_data[i]), 32'(mk(40 + i * 30, 92 + i * 10)));
        end
        check("full_no_ack",     32'(ack_cyc),    32'hFFFF_FFFF);
        check("full_active_cnt", 32'(active_cnt), 32'd16);
        pos_file[7] = DEAD;
        run_pass(1'b1, -1);
        check("refill_ack_cyc",    32'(ack_cyc),     32'd16);
        check("refill_slot7",      32'(pos_file[7]), 32'(mk(312, 356)));
        check("refill_active_cnt", 32'(active_cnt),  32'd16);

        // Asynchronous reset mid-pass at slot 5
        start_pass(1'b0);
        repeat (5) step();
        check("mid_pre_rd_idx", 32'(pf.rd_idx),  32'd5);
        check("mid_pre_wr_en",  32'(pf.wr_en),   32'd1);
        check("mid_pre_active", 32'(active_cnt), 32'd16);
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en",    32'(pf.wr_en),   32'd0);
        check("mid_rst_busy",     32'(busy),       32'd0);
        check("mid_rst_fire_ack", 32'(fire_ack),   32'd0);
        check("mid_rst_active",   32'(active_cnt), 32'd0);
        check("mid_rst_rd_idx",   32'(pf.rd_idx),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        b0 = busy_total;
        run_pass(1'b0, -1);
        check("post_rst_writes", 32'(wlog_idx.size()), 32'd16);
        if (wlog_idx.size() >= 1) begin
            check("post_rst_first_idx", 32'(wlog_idx[0]), 32'd0);
            check("post_rst_first_cyc", 32'(wlog_cyc[0]), 32'd0);
        end
        check("post_rst_busy_cyc", 32'(busy_total - b0), 32'd17);

        // Stray tick at T+5 during a pass is ignored
        do_reset();
        clear_file();
        pos_file[2] = mk(50, 200);
        b0 = busy_total;
        run_pass(1'b0, 4);
        check("retick_busy_cyc", 32'(busy_total - b0), 32'd17);
        check("retick_writes",   32'(wlog_idx.size()), 32'd1);
        if (wlog_idx.size() >= 1) begin
            check("retick_data", 32'(wlog_data[0]), 32'(mk(50, 192)));
        end
        b0 = busy_total;
        repeat (25) step();
        check("retick_no_extra_pass", 32'(busy_total - b0), 32'd0);

        check("wr_idx_tracks_rd_idx", 32'(idx_mismatch), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
